// File: rtl/window_scan_controller.sv
// ---------------------------------------------------------------------------
// window_scan_controller
//
// Walks a WIN x WIN window across an IMG_W x IMG_H frame with stride STEP in
// row-major order (x fastest). Each window origin is offered to a downstream
// classifier with a valid/ready handshake. The block then waits for the
// classifier's result before moving on. Positive results are reported as
// one-cycle detection pulses and counted in a saturating counter.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      one-cycle request to scan a frame (honoured only when idle)
//   busy       high while a scan is in progress
//   win_valid  window origin offered to the classifier
//   win_ready  classifier accepts the offered window
//   win_x/y    top-left origin of the offered window
//   res_valid  classifier result strobe (honoured only while waiting)
//   res_face   result qualifier, 1 = face detected
//   det_valid  one-cycle detection report
//   det_x/y    origin of the reported detection
//   det_count  detections in the current or most recent scan (saturating)
//   done       one-cycle end-of-scan pulse
// All outputs come directly from flops.
// ---------------------------------------------------------------------------
module window_scan_controller #(
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int WIN     = 24,
  parameter int STEP    = 4,
  parameter int COORD_W = 9,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [COORD_W-1:0] win_x,
  output logic [COORD_W-1:0] win_y,
  input  logic               res_valid,
  input  logic               res_face,
  output logic               det_valid,
  output logic [COORD_W-1:0] det_x,
  output logic [COORD_W-1:0] det_y,
  output logic [CNT_W-1:0]   det_count,
  output logic               done
);

  // Unsupported geometry stops elaboration instead of producing a bad scan.
  if (WIN > IMG_W || WIN > IMG_H || STEP < 1) begin : g_bad_params
    $error("window_scan_controller: need WIN <= IMG_W, WIN <= IMG_H and STEP >= 1");
  end

  // The guarded stride only keeps the arithmetic below well-defined when the
  // parameter check above has already fired.
  localparam int STEP_SAFE = (STEP < 1) ? 1 : STEP;
  localparam int NX        = (IMG_W - WIN) / STEP_SAFE + 1;
  localparam int NY        = (IMG_H - WIN) / STEP_SAFE + 1;

  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'((NX - 1) * STEP_SAFE);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'((NY - 1) * STEP_SAFE);
  localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(STEP_SAFE);
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               busy_q, busy_d;
  logic               win_valid_q, win_valid_d;
  logic [COORD_W-1:0] win_x_q, win_x_d;
  logic [COORD_W-1:0] win_y_q, win_y_d;
  logic               det_valid_q, det_valid_d;
  logic [COORD_W-1:0] det_x_q, det_x_d;
  logic [COORD_W-1:0] det_y_q, det_y_d;
  logic [CNT_W-1:0]   det_count_q, det_count_d;
  logic               done_q, done_d;

  logic last_window;
  assign last_window = (win_x_q == X_LAST) && (win_y_q == Y_LAST);

  // Next-state logic. The registered outputs are computed here one cycle
  // ahead, so each output already reflects the state the FSM is entering.
  // The window position doubles as the scan cursor.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    win_valid_d = win_valid_q;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    det_valid_d = 1'b0;
    det_x_d     = det_x_q;
    det_y_d     = det_y_q;
    det_count_d = det_count_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_ISSUE;
          busy_d      = 1'b1;
          win_valid_d = 1'b1;
          win_x_d     = '0;
          win_y_d     = '0;
          det_count_d = '0;
        end
      end

      S_ISSUE: begin
        if (win_valid_q && win_ready) begin
          state_d     = S_WAIT;
          win_valid_d = 1'b0;
        end
      end

      S_WAIT: begin
        if (res_valid) begin
          if (res_face) begin
            det_valid_d = 1'b1;
            det_x_d     = win_x_q;
            det_y_d     = win_y_q;
            if (det_count_q != CNT_MAX) begin
              det_count_d = det_count_q + 1'b1;
            end
          end
          if (last_window) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d     = S_ISSUE;
            win_valid_d = 1'b1;
            // Wrap to the start of the next row once the last column is done.
            if (win_x_q == X_LAST) begin
              win_x_d = '0;
              win_y_d = win_y_q + STEP_C;
            end else begin
              win_x_d = win_x_q + STEP_C;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      win_valid_q <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      det_valid_q <= 1'b0;
      det_x_q     <= '0;
      det_y_q     <= '0;
      det_count_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      win_valid_q <= win_valid_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
      det_valid_q <= det_valid_d;
      det_x_q     <= det_x_d;
      det_y_q     <= det_y_d;
      det_count_q <= det_count_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign win_valid = win_valid_q;
  assign win_x     = win_x_q;
  assign win_y     = win_y_q;
  assign det_valid = det_valid_q;
  assign det_x     = det_x_q;
  assign det_y     = det_y_q;
  assign det_count = det_count_q;
  assign done      = done_q;

endmodule

// File: tb/tb_window_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_window_scan_controller
//
// Directed bench on an 8x6 frame with a 4x4 window and stride 2 (six windows).
// Two instances share the stimulus. One has a 16-bit detection counter and the
// other a 2-bit counter, which shows saturation. Inputs are driven and outputs
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_window_scan_controller;

  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          win_ready = 1'b0;
  logic          res_valid = 1'b0;
  logic          res_face = 1'b0;

  logic          busy, win_valid, det_valid, done;
  logic [CW-1:0] win_x, win_y, det_x, det_y;
  logic [15:0]   det_count;

  logic          s_busy, s_win_valid, s_det_valid, s_done;
  logic [CW-1:0] s_win_x, s_win_y, s_det_x, s_det_y;
  logic [1:0]    s_det_count;

  int checkCount = 0;
  int passCount  = 0;

  int expX [6] = '{0, 2, 4, 0, 2, 4};
  int expY [6] = '{0, 0, 0, 2, 2, 2};

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  window_scan_controller #(
    .IMG_W(8), .IMG_H(6), .WIN(4), .STEP(2), .COORD_W(CW), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_x(win_x), .win_y(win_y),
    .res_valid(res_valid), .res_face(res_face),
    .det_valid(det_valid), .det_x(det_x), .det_y(det_y),
    .det_count(det_count), .done(done)
  );

  window_scan_controller #(
    .IMG_W(8), .IMG_H(6), .WIN(4), .STEP(2), .COORD_W(CW), .CNT_W(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .start(start), .busy(s_busy),
    .win_valid(s_win_valid), .win_ready(win_ready),
    .win_x(s_win_x), .win_y(s_win_y),
    .res_valid(res_valid), .res_face(res_face),
    .det_valid(s_det_valid), .det_x(s_det_x), .det_y(s_det_y),
    .det_count(s_det_count), .done(s_done)
  );

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs at the falling edge. It returns at the next
  // falling edge, after the rising edge has consumed the inputs.
  task automatic applyStimulus(input logic st, input logic rdy,
                               input logic rv, input logic rf);
    start     = st;
    win_ready = rdy;
    res_valid = rv;
    res_face  = rf;
    @(negedge clk);
    start     = 1'b0;
    win_ready = 1'b0;
    res_valid = 1'b0;
    res_face  = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},      busy,      0);
    checkOutput({tag, "_win_valid"}, win_valid, 0);
    checkOutput({tag, "_win_x"},     win_x,     0);
    checkOutput({tag, "_win_y"},     win_y,     0);
    checkOutput({tag, "_det_valid"}, det_valid, 0);
    checkOutput({tag, "_det_x"},     det_x,     0);
    checkOutput({tag, "_det_y"},     det_y,     0);
    checkOutput({tag, "_det_count"}, det_count, 0);
    checkOutput({tag, "_done"},      done,      0);
    checkOutput({tag, "_sat_count"}, s_det_count, 0);
  endtask

  // Runs one frame. faceMask selects which windows report a face. A window
  // index of -1 disables the stall, misuse and abort options.
  task automatic runScan(input string name, input logic [5:0] faceMask,
                         input int stallIdx, input int misuseIdx,
                         input int abortIdx);
    int expCount = 0;
    int pulses   = 0;
    int t;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput({name, "_start_busy"},  busy,      1);
    checkOutput({name, "_start_count"}, det_count, 0);
    for (int i = 0; i < 6; i++) begin
      t = 0;
      while (win_valid !== 1'b1 && t < 20) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        t++;
      end
      checkOutput($sformatf("%s_w%0d_valid", name, i), win_valid, 1);
      checkOutput($sformatf("%s_w%0d_x", name, i), win_x, expX[i]);
      checkOutput($sformatf("%s_w%0d_y", name, i), win_y, expY[i]);
      if (win_valid !== 1'b1) return;

      if (i == stallIdx) begin
        for (int k = 0; k < 3; k++) begin
          applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
          checkOutput($sformatf("%s_stall%0d_valid", name, k), win_valid, 1);
          checkOutput($sformatf("%s_stall%0d_x", name, k), win_x, expX[i]);
          checkOutput($sformatf("%s_stall%0d_y", name, k), win_y, expY[i]);
        end
      end

      if (i == misuseIdx) begin
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput({name, "_misuse_valid"}, win_valid, 1);
        checkOutput({name, "_misuse_x"},     win_x,     expX[i]);
        checkOutput({name, "_misuse_y"},     win_y,     expY[i]);
        checkOutput({name, "_misuse_det"},   det_valid, 0);
        checkOutput({name, "_misuse_count"}, det_count, expCount);
      end

      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("%s_w%0d_hs_valid", name, i), win_valid, 0);
      checkOutput($sformatf("%s_w%0d_hs_busy", name, i), busy, 1);

      if (i == abortIdx) begin
        if (misuseIdx < 0) begin
          // A start during WAIT must not disturb the scan either.
          applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
          checkOutput({name, "_wait_start_valid"}, win_valid, 0);
        end
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checkAllZero({name, "_abort"});
        for (int k = 0; k < 4; k++) begin
          applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
          checkOutput($sformatf("%s_post_abort%0d_done", name, k), done, 0);
          checkOutput($sformatf("%s_post_abort%0d_busy", name, k), busy, 0);
        end
        return;
      end

      applyStimulus(1'b0, 1'b0, 1'b1, faceMask[i]);
      if (faceMask[i]) expCount++;
      pulses += int'(det_valid);
      checkOutput($sformatf("%s_w%0d_det", name, i), det_valid, faceMask[i]);
      checkOutput($sformatf("%s_w%0d_sat_det", name, i), s_det_valid, faceMask[i]);
      if (faceMask[i]) begin
        checkOutput($sformatf("%s_w%0d_det_x", name, i), det_x, expX[i]);
        checkOutput($sformatf("%s_w%0d_det_y", name, i), det_y, expY[i]);
      end
      checkOutput($sformatf("%s_w%0d_count", name, i), det_count, expCount);
      checkOutput($sformatf("%s_w%0d_sat_count", name, i), s_det_count,
                  (expCount > 3) ? 3 : expCount);
      if (i < 5) begin
        checkOutput($sformatf("%s_w%0d_done", name, i), done, 0);
        checkOutput($sformatf("%s_w%0d_busy", name, i), busy, 1);
        checkOutput($sformatf("%s_w%0d_next_valid", name, i), win_valid, 1);
      end else begin
        checkOutput({name, "_done_pulse"}, done,      1);
        checkOutput({name, "_done_busy"},  busy,      0);
        checkOutput({name, "_done_valid"}, win_valid, 0);
      end
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput({name, "_done_drop"},  done,      0);
    checkOutput({name, "_det_drop"},   det_valid, 0);
    checkOutput({name, "_pulses"},     pulses,    $countones(faceMask));
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("%s_hold%0d_count", name, k), det_count, expCount);
      checkOutput($sformatf("%s_hold%0d_done", name, k), done, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkAllZero("reset");

    // A result strobe while idle must not count anything.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("idle_res_det",   det_valid, 0);
    checkOutput("idle_res_count", det_count, 0);

    $display("[TB] test 1: plain scan");
    runScan("t1", 6'b000000, -1, -1, -1);
    $display("[TB] test 2: faces on windows 2 and 5");
    runScan("t2", 6'b010010, -1, -1, -1);
    $display("[TB] test 3: stall on window (4,0)");
    runScan("t3", 6'b000000, 2, -1, -1);
    $display("[TB] test 4: reset during WAIT of window 3");
    runScan("t4", 6'b000000, -1, -1, 2);
    $display("[TB] test 5: start and result while in ISSUE");
    runScan("t5", 6'b000100, -1, 1, -1);
    $display("[TB] test 6: faces everywhere, counter saturation");
    runScan("t6", 6'b111111, -1, -1, -1);
    checkOutput("t6_sat_final", s_det_count, 3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Safety net in case a scan never finishes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
